// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the
// architectural HI/LO registers. The multiply has a fixed latency. The divide
// is radix-2 restoring on magnitudes: 32 iterations followed by one sign-fix
// cycle. busy and done are registered so they can feed hazard logic directly.
module muldiv_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    // Operand magnitudes for the divider; only signed DIV strips the sign.
    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] a_abs_d;
    logic [31:0] b_abs_d;

    // Product, divider step and sign-fixed results.
    logic [63:0] prod_d;
    logic [32:0] trial_d;
    logic [31:0] rem_step_d;
    logic [31:0] quo_step_d;
    logic [31:0] quo_fix_d;
    logic [31:0] rem_fix_d;

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Absolute values of the live operands, loaded into the divider at start.
    always_comb begin
        a_neg_d = op[0] & src_a[31];
        b_neg_d = op[0] & src_b[31];
        a_abs_d = a_neg_d ? (32'd0 - src_a) : src_a;
        b_abs_d = b_neg_d ? (32'd0 - src_b) : src_b;
    end

    // 64x64 product of the sign- or zero-extended operands; the low 64 bits
    // are the correct two's complement result for both MULT and MULTU.
    always_comb begin
        prod_d = {{32{op_q[0] & a_q[31]}}, a_q} * {{32{op_q[0] & b_q[31]}}, b_q};
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when the partial remainder allows it.
    always_comb begin
        trial_d = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        if (!trial_d[32]) begin
            rem_step_d = trial_d[31:0];
            quo_step_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_step_d = {rem_q[30:0], quo_q[31]};
            quo_step_d = {quo_q[30:0], 1'b0};
        end
    end

    // Signed DIV: quotient negative when the signs differ, remainder follows
    // the dividend. The 0x80000000 / -1 case falls out naturally as 0x80000000.
    always_comb begin
        quo_fix_d = (op_q[0] & (a_q[31] ^ b_q[31])) ? (32'd0 - quo_q) : quo_q;
        rem_fix_d = (op_q[0] & a_q[31]) ? (32'd0 - rem_q) : rem_q;
    end

    // Control FSM with registered busy/done and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            op_q   <= op;
                            a_q    <= src_a;
                            b_q    <= src_b;
                            busy_q <= 1'b1;
                            if (op[1]) begin
                                state_q <= DIV;
                                cnt_q   <= 5'd31;
                                quo_q   <= a_abs_d;
                                dvs_q   <= b_abs_d;
                                rem_q   <= 32'd0;
                            end else begin
                                state_q <= MUL;
                                cnt_q   <= 5'(MUL_LAT - 1);
                            end
                        end else begin
                            if (mt_hi) hi_q <= mt_data;
                            if (mt_lo) lo_q <= mt_data;
                        end
                    end
                    MUL: begin
                        if (cnt_q == 5'd0) begin
                            hi_q    <= prod_d[63:32];
                            lo_q    <= prod_d[31:0];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    DIV: begin
                        rem_q <= rem_step_d;
                        quo_q <= quo_step_d;
                        if (cnt_q == 5'd0) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    FIX: begin
                        // Divide by zero reports all-ones quotient and the raw dividend.
                        if (b_q == 32'd0) begin
                            lo_q <= 32'hFFFF_FFFF;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= quo_fix_d;
                            hi_q <= rem_fix_d;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .mt_hi   (mt_hi),
        .mt_lo   (mt_lo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        int          q;
        int          r;
        case (mop)
            2'd0: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            2'd1: begin
                sa = a;
                sb = b;
                sp = longint'(sa) * longint'(sb);
                return 64'(sp);
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Drive a start for one edge, then scramble the operand inputs so the
    // captured copies are what must be used. Returns in the cycle after E0.
    task automatic issue(input logic [1:0] iop, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = iop;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Wait for done (bounded), checking busy each cycle, latency and result.
    task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_hl);
        int cyc  = 0;
        bit seen = 1'b0;
        while (cyc <= 60) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk({tag, ":busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            cyc++;
        end
        chk({tag, ":latency"}, seen ? 64'(cyc) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_lat));
        if (seen) begin
            chk({tag, ":busy_at_done"}, 64'(busy), 64'd0);
            chk({tag, ":hilo"}, {hi, lo}, exp_hl);
            $display("op %s -> hi=%h lo=%h after %0d cycles", tag, hi, lo, cyc);
        end
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
        mt_hi   = wh;
        mt_lo   = wl;
        mt_data = d;
        @(negedge clk);
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          any_done;

        rst     = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        src_a   = 32'd0;
        src_b   = 32'd0;
        flush   = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        mt_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset:busy", 64'(busy), 64'd0);
        chk("reset:done", 64'(done), 64'd0);
        chk("reset:hilo", {hi, lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Signed multiply, single-cycle done pulse.
        issue(2'd1, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult", MUL_LAT, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        @(negedge clk);
        chk("mult:done_one_cycle", 64'(done), 64'd0);

        // Unsigned multiply then DIVU issued in the done cycle.
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", MUL_LAT, {32'hFFFF_FFFE, 32'h0000_0001});
        issue(2'd2, 32'd100, 32'd7);
        wait_done("divu_b2b", DIV_LAT, {32'd2, 32'd14});

        // Signed divide, overflow, divide by zero.
        issue(2'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", DIV_LAT, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", DIV_LAT, {32'd0, 32'h8000_0000});
        issue(2'd2, 32'd5, 32'd0);
        wait_done("divu_zero", DIV_LAT, {32'd5, 32'hFFFF_FFFF});
        issue(2'd3, 32'hFFFF_FFF0, 32'd0);
        wait_done("div_zero", DIV_LAT, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

        // MT writes, then flush mid-divide with start/mt attempts while busy.
        mt_write(1'b1, 1'b0, 32'h1111_1111);
        chk("mthi", 64'(hi), 64'h1111_1111);
        mt_write(1'b0, 1'b1, 32'h2222_2222);
        chk("mtlo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
        issue(2'd2, 32'd9, 32'd3);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        op      = 2'd0;
        mt_hi   = 1'b1;
        mt_lo   = 1'b1;
        mt_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush:busy", 64'(busy), 64'd0);
        chk("flush:done", 64'(done), 64'd0);
        any_done = 1'b0;
        repeat (40) begin
            if (done) any_done = 1'b1;
            @(negedge clk);
        end
        chk("flush:no_done_later", 64'(any_done), 64'd0);
        chk("flush:hilo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});

        // Start and MT while a multiply is in flight are ignored.
        issue(2'd0, 32'd2, 32'd3);
        start   = 1'b1;
        op      = 2'd2;
        mt_hi   = 1'b1;
        mt_data = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        mt_hi = 1'b0;
        wait_done("multu_ignore", MUL_LAT - 1, {32'd0, 32'd6});
        @(negedge clk);
        chk("ignore:idle_after", 64'(busy), 64'd0);

        // Reset in the middle of a multiply and of a divide.
        mt_write(1'b1, 1'b1, 32'h5555_5555);
        issue(2'd0, $urandom, $urandom);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mul:busy", 64'(busy), 64'd0);
        chk("rst_mul:done", 64'(done), 64'd0);
        chk("rst_mul:hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_mul:stays_idle", {63'd0, busy | done}, 64'd0);
        mt_write(1'b1, 1'b1, 32'hAAAA_AAAA);
        issue(2'd2, $urandom, 32'd7);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_div:busy", 64'(busy), 64'd0);
        chk("rst_div:done", 64'(done), 64'd0);
        chk("rst_div:hilo", {hi, lo}, 64'd0);
        issue(2'd0, 32'd3, 32'd4);
        wait_done("multu_after_rst", MUL_LAT, {32'd0, 32'h0C});

        // Randomized operations, issued back-to-back in each done cycle.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'($urandom_range(0, 50));
                default: ;
            endcase
            issue(rop, ra, rb);
            wait_done($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb),
                      rop[1] ? DIV_LAT : MUL_LAT, model(rop, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
